// File: rtl/pled_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pled_pkg : shared state encoding and colour constants for the LED sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package pled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FADE_IN   = 3'd2,
    ST_HOLD      = 3'd3,
    ST_FADE_OUT  = 3'd4,
    ST_NEXT      = 3'd5
  } state_t;

  localparam logic [2:0] COLOR_FIRST = 3'd1;
  localparam logic [2:0] COLOR_LAST  = 3'd7;

  // Colour 0 means "all off" and is skipped once the sequence is running.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == COLOR_LAST) ? COLOR_FIRST : c + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pled_pwm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pled_pwm : free-running PWM counter with registered duty compare
// Rev 1.0
// ---------------------------------------------------------------------------
module pled_pwm #(
  parameter int PWM_W = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [PWM_W-1:0] i_duty,
  input  logic             i_active,
  output logic             o_led
);

  logic [PWM_W-1:0] r_pwm_cnt;
  logic             r_led;

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_pwm_cnt <= '0;
      r_led     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      r_led     <= i_active && (r_pwm_cnt < i_duty);
    end
  end

  assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/pled_color_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pled_color_sequencer : fades each RGB combination in, holds, fades out, steps
// Rev 1.0
// ---------------------------------------------------------------------------
module pled_color_sequencer
  import pled_pkg::*;
#(
  parameter int PWM_W      = 8,
  parameter int STEP_DIV   = 39,
  parameter int HOLD_TICKS = 256
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             enable,
  output logic [2:0]       color,
  output logic             led,
  output logic [PWM_W-1:0] duty,
  output logic [2:0]       state_o,
  output logic             cycle_done
);

  localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HOLD_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]  C_HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [PWM_W-1:0]   C_DUTY_MAX   = '1;
  localparam logic [PWM_W-1:0]   C_DUTY_NEAR  = C_DUTY_MAX - PWM_W'(1);

  state_t             r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [HOLD_W-1:0]  r_hold;
  logic [PWM_W-1:0]   r_duty;
  logic [2:0]         r_color;
  logic               r_done;

  logic w_tick;
  logic w_active;

  assign w_tick   = (r_presc == C_PRESC_LAST);
  assign w_active = (r_state == ST_FADE_IN) || (r_state == ST_HOLD) || (r_state == ST_FADE_OUT);

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_presc <= '0;
      r_hold  <= '0;
      r_duty  <= '0;
      r_color <= 3'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if ((r_state == ST_IDLE) || (r_state == ST_WAIT_LOCK) || w_tick)
        r_presc <= '0;
      else
        r_presc <= r_presc + PRESC_W'(1);

      // A lost enable or lock always wins over a pending tick.
      if (!enable) begin
        r_state <= ST_IDLE;
        r_duty  <= '0;
      end else if (!pll_lock) begin
        r_state <= ST_WAIT_LOCK;
        r_duty  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_WAIT_LOCK;
          ST_WAIT_LOCK: begin
            r_state <= ST_FADE_IN;
            if (r_color == 3'd0) r_color <= COLOR_FIRST;
          end
          ST_FADE_IN: if (w_tick) begin
            if (r_duty != C_DUTY_MAX) r_duty <= r_duty + PWM_W'(1);
            if (r_duty >= C_DUTY_NEAR) begin
              r_state <= ST_HOLD;
              r_hold  <= '0;
            end
          end
          ST_HOLD: if (w_tick) begin
            if (r_hold == C_HOLD_LAST) r_state <= ST_FADE_OUT;
            else                       r_hold  <= r_hold + HOLD_W'(1);
          end
          ST_FADE_OUT: if (w_tick) begin
            if (r_duty <= PWM_W'(1)) begin
              r_duty  <= '0;
              r_state <= ST_NEXT;
            end else begin
              r_duty <= r_duty - PWM_W'(1);
            end
          end
          ST_NEXT: begin
            r_color <= next_color(r_color);
            r_done  <= (r_color == COLOR_LAST);
            r_state <= ST_FADE_IN;
          end
          default: begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
          end
        endcase
      end
    end
  end

  pled_pwm #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .i_duty   (r_duty),
    .i_active (w_active),
    .o_led    (led)
  );

  assign color      = r_color;
  assign duty       = r_duty;
  assign state_o    = r_state;
  assign cycle_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pled_color_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pled_color_sequencer : randomized run against a cycle-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pled_color_sequencer;

  localparam int PWM_W      = 4;
  localparam int STEP_DIV   = 2;
  localparam int HOLD_TICKS = 4;
  localparam int DMAX       = (1 << PWM_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, en, lk;
  logic [2:0]       color, state_o;
  logic             led, cycle_done;
  logic [PWM_W-1:0] duty;

  logic             s_rst_n, s_en, s_lk;
  logic [2:0]       s_color, s_state;
  logic             s_led, s_done;
  logic [PWM_W-1:0] s_duty;

  pled_color_sequencer #(
    .PWM_W(PWM_W), .STEP_DIV(STEP_DIV), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .sys_clk(clk), .reset(rst_n), .pll_lock(lk), .enable(en),
    .color(color), .led(led), .duty(duty), .state_o(state_o), .cycle_done(cycle_done)
  );

  // Slow-fade instance so a single duty value persists across whole PWM periods.
  pled_color_sequencer #(
    .PWM_W(PWM_W), .STEP_DIV(40), .HOLD_TICKS(1)
  ) dut_slow (
    .sys_clk(clk), .reset(s_rst_n), .pll_lock(s_lk), .enable(s_en),
    .color(s_color), .led(s_led), .duty(s_duty), .state_o(s_state), .cycle_done(s_done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase names as integers, plain arithmetic on counts.
  int m_state, m_color, m_duty, m_led, m_done, m_pwm, m_presc, m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit l);
    bit tick;
    if (!r) begin
      m_state = 0; m_color = 0; m_duty = 0; m_led = 0;
      m_done = 0; m_pwm = 0; m_presc = 0; m_hold = 0;
      return;
    end
    tick    = (m_presc == STEP_DIV - 1);
    m_led   = (m_pwm < m_duty) && (m_state >= 2) && (m_state <= 4);
    m_pwm   = (m_pwm + 1) % (DMAX + 1);
    m_presc = (m_state <= 1 || tick) ? 0 : m_presc + 1;
    m_done  = 0;
    if (!e) begin
      m_state = 0; m_duty = 0;
    end else if (!l) begin
      m_state = 1; m_duty = 0;
    end else begin
      case (m_state)
        0: m_state = 1;
        1: begin
          m_state = 2;
          if (m_color == 0) m_color = 1;
        end
        2: if (tick) begin
          m_duty = (m_duty < DMAX) ? m_duty + 1 : DMAX;
          if (m_duty == DMAX) begin m_state = 3; m_hold = 0; end
        end
        3: if (tick) begin
          if (m_hold == HOLD_TICKS - 1) m_state = 4;
          else m_hold = m_hold + 1;
        end
        4: if (tick) begin
          m_duty = (m_duty > 0) ? m_duty - 1 : 0;
          if (m_duty == 0) m_state = 5;
        end
        default: begin
          if (m_color == 7) begin m_color = 1; m_done = 1; end
          else m_color = m_color + 1;
          m_state = 2;
        end
      endcase
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit l);
    rst_n = r; en = e; lk = l;
    model_step(r, e, l);
    @(negedge clk);
    check("state", 32'(state_o), m_state);
    check("color", 32'(color), m_color);
    check("duty", 32'(duty), m_duty);
    check("led", 32'(led), m_led);
    check("cycle_done", 32'(cycle_done), m_done);
  endtask

  initial begin
    int guard, hi;
    bit found;
    s_rst_n = 1'b0; s_en = 1'b0; s_lk = 1'b0;

    // Reset, then enabled but unlocked: parks in WAIT_LOCK with colour off.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(1, 1, 0);

    // Locked free run long enough to wrap 7 -> 1 at least once.
    for (int i = 0; i < 1200; i++) cycle(1, 1, 1);

    // Lock drop while holding colour 3, then relock.
    guard = 0;
    while (!(m_state == 3 && m_color == 3) && guard < 2000) begin
      cycle(1, 1, 1); guard++;
    end
    check("reach_hold_color3", 32'(guard < 2000), 1);
    cycle(1, 1, 0);
    for (int i = 0; i < 40; i++) cycle(1, 1, 1);

    // Enable drop during fade-out, then resume.
    guard = 0;
    while (m_state != 4 && guard < 2000) begin
      cycle(1, 1, 1); guard++;
    end
    check("reach_fade_out", 32'(guard < 2000), 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1);
    for (int i = 0; i < 100; i++) cycle(1, 1, 1);

    // Random glitches on reset, enable and lock.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(1999) != 0, $urandom_range(149) != 0, $urandom_range(99) != 0);

    // PWM duty-cycle count on the slow instance.
    s_rst_n = 1'b1; s_en = 1'b1; s_lk = 1'b1;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 600) begin
      @(negedge clk);
      if (s_duty == PWM_W'(5)) found = 1'b1;
      guard++;
    end
    check("slow_duty5_reached", 32'(found), 1);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hi += int'(s_led);
    end
    check("pwm_high_at_duty5", hi, 5);

    s_lk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("slow_state_wait_lock", 32'(s_state), 1);
    check("slow_duty_cleared", 32'(s_duty), 0);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      hi += int'(s_led);
    end
    check("pwm_high_at_duty0", hi, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
